// File: rtl/serial_mem_slave_if.sv
// Serial bus + BRAM port bundle for serial_mem_slave.
// slave: rx,bram_q in; tx,busy,done,bram_wr/address/data out.
interface serial_mem_slave_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     rx;
  logic                     tx;
  logic                     busy;
  logic                     done;
  logic                     bram_wr;
  logic [ADDRESS_WIDTH-1:0] bram_address;
  logic [DATA_WIDTH-1:0]    bram_data;
  logic [DATA_WIDTH-1:0]    bram_q;

  modport slave (
    input  rx,
    input  bram_q,
    output tx,
    output busy,
    output done,
    output bram_wr,
    output bram_address,
    output bram_data
  );

  modport master (
    output rx,
    output bram_q,
    input  tx,
    input  busy,
    input  done,
    input  bram_wr,
    input  bram_address,
    input  bram_data
  );
endinterface

// File: rtl/serial_mem_slave.sv
// Bit-serial read/write front end for a slave BRAM.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module serial_mem_slave #(
  parameter int MEMORY_DEPTH  = 4096,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  serial_mem_slave_if.slave bus
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  // Counter reload values: a field ends on the bit seen at zero.
  localparam logic [CW-1:0] AW_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(MEMORY_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RADDR,
    S_RLOAD,
    S_TXSTART,
    S_TXDATA
  } state_e;

  state_e          state_q;
  logic            cmd_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdat_q;
  logic [DW-1:0]   tsh_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            wr_q;

  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdat_d;
  logic [DW-1:0]   tsh_d;
  logic            in_range;

  always_comb begin
    addr_d   = {addr_q[AW-2:0], bus.rx};
    wdat_d   = {wdat_q[DW-2:0], bus.rx};
    tsh_d    = {tsh_q[DW-2:0], 1'b0};
    in_range = ({1'b0, addr_q} < DEPTH);
  end

  // The address is shifted straight into the BRAM address
  // register; it is only meaningful after ADDR completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      tsh_q   <= '0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.rx) begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
          end
        end
        S_CMD: begin
          cmd_q   <= bus.rx;
          cnt_q   <= AW_LAST;
          state_q <= S_ADDR;
        end
        S_ADDR: begin
          addr_q <= addr_d;
          if (cnt_q == '0) begin
            if (cmd_q) begin
              state_q <= S_WDATA;
              cnt_q   <= DW_LAST;
            end else begin
              state_q <= S_RADDR;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_WDATA: begin
          wdat_q <= wdat_d;
          if (cnt_q == '0) begin
            state_q <= S_WRITE;
            wr_q    <= in_range;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          wr_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_RADDR: begin
          state_q <= S_RLOAD;
        end
        S_RLOAD: begin
          tsh_q   <= in_range ? bus.bram_q : '0;
          tx_q    <= 1'b1;
          state_q <= S_TXSTART;
        end
        S_TXSTART: begin
          tx_q    <= tsh_q[DW-1];
          tsh_q   <= tsh_d;
          cnt_q   <= DW_LAST;
          state_q <= S_TXDATA;
        end
        S_TXDATA: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            tx_q   <= tsh_q[DW-1];
            tsh_q  <= tsh_d;
            cnt_q  <= cnt_q - ONE;
            // Raise done so it lines up with the final bit.
            done_q <= (cnt_q == ONE);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx           = tx_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.bram_wr      = wr_q;
  assign bus.bram_address = addr_q;
  assign bus.bram_data    = wdat_q;
endmodule

// File: tb/tb_serial_mem_slave.sv
// Self-checking bench for serial_mem_slave.
// Two DUTs: depth 4096 (main) and depth 3000 (out-of-range).
module tb_serial_mem_slave;
  localparam int DW   = 16;
  localparam int AW   = 12;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rxv;
  int         cyc = 0;
  int         checks = 0;
  int         errs = 0;
  logic       chk_en = 1'b0;

  serial_mem_slave_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) b0 ();
  serial_mem_slave_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) b1 ();

  serial_mem_slave #(
    .MEMORY_DEPTH(4096),
    .DATA_WIDTH(DW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(b0)
  );

  serial_mem_slave #(
    .MEMORY_DEPTH(3000),
    .DATA_WIDTH(DW)
  ) u_oor (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM behind the main DUT: one-cycle registered read.
  logic [DW-1:0] mem0 [4096];
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;
  always @(posedge clk) begin
    if (b0.bram_wr) mem0[b0.bram_address] <= b0.bram_data;
    q0 <= mem0[b0.bram_address];
    // Second BRAM is a never-written array of all ones.
    q1 <= 16'hFFFF;
  end

  assign b0.rx     = rxv[0];
  assign b1.rx     = rxv[1];
  assign b0.bram_q = q0;
  assign b1.bram_q = q1;

  // Expected per-cycle outputs: {busy, done, wr, tx}.
  logic [3:0]    ex [2][MAXC];
  logic [AW-1:0] ea [2][MAXC];
  logic [DW-1:0] ed [2][MAXC];
  logic [DW-1:0] mdl [4096];

  function automatic int depth(input int d);
    return (d == 0) ? 4096 : 3000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // Drives a write frame starting this cycle. abort_at>0 pulses
  // rst on that frame cycle instead of completing.
  task automatic wr_frame(input int d, input logic [AW-1:0] a,
                          input logic [DW-1:0] v, input int abort_at);
    int t0;
    int last;
    logic [AW+DW+1:0] f;
    t0   = cyc;
    f    = {2'b11, a, v};
    last = (abort_at > 0) ? abort_at : 2 + AW + DW;
    for (int c = 1; c <= last; c++) ex[d][t0+c][3] = 1'b1;
    if (abort_at == 0) begin
      ex[d][t0+2+AW+DW][2] = 1'b1;
      if (int'(a) < depth(d)) begin
        ex[d][t0+2+AW+DW][1] = 1'b1;
        ea[d][t0+2+AW+DW]    = a;
        ed[d][t0+2+AW+DW]    = v;
        if (d == 0) mdl[a] = v;
      end
    end
    for (int i = 0; i < 2 + AW + DW; i++) begin
      if (abort_at > 0 && i == abort_at) begin
        rxv[d] = 1'b0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        return;
      end
      rxv[d] = f[AW+DW+1-i];
      step();
    end
    rxv[d] = 1'b0;
    step();
  endtask

  // Drives a read frame and collects the 16 returned bits.
  task automatic rd_frame(input int d, input logic [AW-1:0] a,
                          output logic [DW-1:0] got);
    int t0;
    logic [DW-1:0] e;
    logic [AW+1:0] f;
    logic txb;
    t0 = cyc;
    f  = {2'b10, a};
    if (int'(a) >= depth(d)) e = '0;
    else if (d == 0) e = mdl[a];
    else e = 16'hFFFF;
    for (int c = 1; c <= 16 + DW; c++) ex[d][t0+c][3] = 1'b1;
    ex[d][t0+16][0] = 1'b1;
    for (int k = 0; k < DW; k++) ex[d][t0+17+k][0] = e[DW-1-k];
    ex[d][t0+16+DW][2] = 1'b1;
    for (int i = 0; i < AW + 2; i++) begin
      rxv[d] = f[AW+1-i];
      step();
    end
    rxv[d] = 1'b0;
    got = '0;
    while (cyc <= t0 + 16 + DW) begin
      txb = (d == 0) ? b0.tx : b1.tx;
      if (cyc >= t0 + 17) got = {got[DW-2:0], txb};
      step();
    end
  endtask

  task automatic idle_zero(input string n, input int d);
    logic [3:0] g;
    g = (d == 0) ? {b0.busy, b0.done, b0.bram_wr, b0.tx}
                 : {b1.busy, b1.done, b1.bram_wr, b1.tx};
    chk(n, {28'd0, g}, 32'd0);
  endtask

  logic [DW-1:0] got;

  initial begin
    rst = 1'b1;
    rxv = 2'b00;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < MAXC; c++) begin
        ex[d][c] = '0;
        ea[d][c] = '0;
        ed[d][c] = '0;
      end
    for (int i = 0; i < 4096; i++) mdl[i] = '0;

    fork
      begin : cmp
        logic [3:0]    g;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        forever begin
          @(negedge clk);
          if (chk_en && cyc < MAXC) begin
            for (int d = 0; d < 2; d++) begin
              g = (d == 0) ? {b0.busy, b0.done, b0.bram_wr, b0.tx}
                           : {b1.busy, b1.done, b1.bram_wr, b1.tx};
              checks++;
              if (g !== ex[d][cyc]) begin
                errs++;
                $display("FAIL outs dut=%0d cyc=%0d busy/done/wr/tx got=%b exp=%b",
                         d, cyc, g, ex[d][cyc]);
              end
              if (ex[d][cyc][1]) begin
                ga = (d == 0) ? b0.bram_address : b1.bram_address;
                gd = (d == 0) ? b0.bram_data : b1.bram_data;
                checks++;
                if (ga !== ea[d][cyc] || gd !== ed[d][cyc]) begin
                  errs++;
                  $display("FAIL wrbus dut=%0d cyc=%0d got=%h/%h exp=%h/%h",
                           d, cyc, ga, gd, ea[d][cyc], ed[d][cyc]);
                end
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_zero("reset_outs0", 0);
    idle_zero("reset_outs1", 1);
    chk("reset_addr", {20'd0, b0.bram_address}, 32'd0);
    chk("reset_data", {16'd0, b0.bram_data}, 32'd0);
    chk_en = 1'b1;
    step();

    wr_frame(0, 12'h0A5, 16'hBEEF, 0);
    chk("wr_mem", {16'd0, mem0[12'h0A5]}, 32'h0000BEEF);
    repeat (3) step();
    rd_frame(0, 12'h0A5, got);
    chk("rd_beef", {16'd0, got}, 32'h0000BEEF);
    repeat (2) step();

    wr_frame(0, 12'h001, 16'h1234, 0);
    rd_frame(0, 12'h001, got);
    chk("b2b_1234", {16'd0, got}, 32'h00001234);
    repeat (2) step();

    wr_frame(0, 12'h0A5, 16'h5555, 20);
    idle_zero("rst_mid_outs", 0);
    chk("rst_mid_addr", {20'd0, b0.bram_address}, 32'd0);
    chk("rst_mid_data", {16'd0, b0.bram_data}, 32'd0);
    step();
    chk("rst_mid_mem", {16'd0, mem0[12'h0A5]}, 32'h0000BEEF);
    rd_frame(0, 12'h0A5, got);
    chk("rst_mid_rd", {16'd0, got}, 32'h0000BEEF);

    repeat (100) step();
    idle_zero("idle_noise", 0);

    wr_frame(1, 12'hFFF, 16'hA5A5, 0);
    rd_frame(1, 12'hFFF, got);
    chk("oor_rd", {16'd0, got}, 32'h00000000);
    step();
    rd_frame(1, 12'h010, got);
    chk("inr_rd", {16'd0, got}, 32'h0000FFFF);
    repeat (3) step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
